// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   AW        register address width
//   TW        Tnew/Tuse width
//   TUSE_NONE Tuse code for "operand not read"
//   fwd_sel_t forwarding source select (regfile, E, M, W)
//   slot_t    one tracked pipeline stage: destination register + remaining Tnew
package hazard_pkg;

    localparam int AW = 5;
    localparam int TW = 2;
    localparam logic [TW-1:0] TUSE_NONE = TW'(3);

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [TW-1:0] tnew;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '0;

    // One stage of ageing: Tnew counts down and holds at zero.
    function automatic slot_t age_slot(slot_t s);
        slot_t r;
        r.dst  = s.dst;
        r.tnew = (s.tnew == '0) ? '0 : s.tnew - TW'(1);
        return r;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Nearest-match resolver for one source operand.
// Scans the E, M and W slots in that order; only the first slot whose
// destination equals the operand counts. Register 0 never matches.
//   r         operand register address
//   tuse      cycles until the operand is needed (TUSE_NONE = not read)
//   slot_e/m/w  tracked stages, nearest first
//   stall_bit result not ready in time for this operand
//   fwd_sel   stage to forward from when its result is ready, else FWD_RF
module hazard_match
    import hazard_pkg::*;
(
    input  logic [AW-1:0] r,
    input  logic [TW-1:0] tuse,
    input  slot_t         slot_e,
    input  slot_t         slot_m,
    input  slot_t         slot_w,
    output logic          stall_bit,
    output fwd_sel_t      fwd_sel
);

    logic          hit;
    logic [TW-1:0] hit_tnew;
    fwd_sel_t      hit_stage;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_stage = FWD_RF;

        if (r != '0) begin
            if (slot_e.dst == r) begin
                hit       = 1'b1;
                hit_tnew  = slot_e.tnew;
                hit_stage = FWD_E;
            end else if (slot_m.dst == r) begin
                hit       = 1'b1;
                hit_tnew  = slot_m.tnew;
                hit_stage = FWD_M;
            end else if (slot_w.dst == r) begin
                hit       = 1'b1;
                hit_tnew  = slot_w.tnew;
                hit_stage = FWD_W;
            end
        end

        stall_bit = hit && (tuse != TUSE_NONE) && (hit_tnew > tuse);
        fwd_sel   = (hit && (hit_tnew == '0)) ? hit_stage : FWD_RF;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Tnew/Tuse hazard controller for the 5-stage pipeline.
// Tracks {dst, tnew} for the instructions in E, M and W and resolves the
// D-stage operands against them.
//   clk, reset           pipeline clock, asynchronous active-high reset
//   rs_d, rt_d           D-stage source registers
//   tuse_rs_d, tuse_rt_d D-stage Tuse per operand
//   dst_d, tnew_d        D-stage destination and its Tnew on entering E
//   flush                bubble E at the next edge
//   stall                hold F/D, bubble D/E (combinational)
//   fwd_rs_d, fwd_rt_d   D-stage forwarding selects (combinational)
//   fwd_rs_e, fwd_rt_e   E-stage forwarding selects (registered with D/E)
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic [AW-1:0] dst_d,
    input  logic [TW-1:0] tnew_d,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e
);

    slot_t         slot_e;
    slot_t         slot_m;
    slot_t         slot_w;
    logic [AW-1:0] rs_e;
    logic [AW-1:0] rt_e;

    logic     stall_rs;
    logic     stall_rt;
    fwd_sel_t sel_rs_d;
    fwd_sel_t sel_rt_d;

    // Slots as they will stand after the next edge, used to precompute the
    // E-stage selects for the instruction currently in D.
    slot_t    nx_m;
    slot_t    nx_w;
    logic     pre_stall_rs;
    logic     pre_stall_rt;
    fwd_sel_t sel_rs_nx;
    fwd_sel_t sel_rt_nx;

    logic bubble;

    hazard_match u_match_rs (
        .r        (rs_d),
        .tuse     (tuse_rs_d),
        .slot_e   (slot_e),
        .slot_m   (slot_m),
        .slot_w   (slot_w),
        .stall_bit(stall_rs),
        .fwd_sel  (sel_rs_d)
    );

    hazard_match u_match_rt (
        .r        (rt_d),
        .tuse     (tuse_rt_d),
        .slot_e   (slot_e),
        .slot_m   (slot_m),
        .slot_w   (slot_w),
        .stall_bit(stall_rt),
        .fwd_sel  (sel_rt_d)
    );

    assign nx_m = age_slot(slot_e);
    assign nx_w = '{dst: slot_m.dst, tnew: '0};

    // E slot is masked: an instruction never forwards to itself, so the
    // E-stage select can only be M or W. Tuse is irrelevant here.
    hazard_match u_pre_rs (
        .r        (rs_d),
        .tuse     (TUSE_NONE),
        .slot_e   (EMPTY_SLOT),
        .slot_m   (nx_m),
        .slot_w   (nx_w),
        .stall_bit(pre_stall_rs),
        .fwd_sel  (sel_rs_nx)
    );

    hazard_match u_pre_rt (
        .r        (rt_d),
        .tuse     (TUSE_NONE),
        .slot_e   (EMPTY_SLOT),
        .slot_m   (nx_m),
        .slot_w   (nx_w),
        .stall_bit(pre_stall_rt),
        .fwd_sel  (sel_rt_nx)
    );

    assign stall    = stall_rs | stall_rt;
    assign bubble   = stall | flush;
    assign fwd_rs_d = sel_rs_d;
    assign fwd_rt_d = sel_rt_d;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every slot
        // shifts from the pre-edge values, independent of statement order.
        if (reset) begin
            slot_e   <= '0;
            slot_m   <= '0;
            slot_w   <= '0;
            rs_e     <= '0;
            rt_e     <= '0;
            fwd_rs_e <= FWD_RF;
            fwd_rt_e <= FWD_RF;
        end else begin
            slot_w <= nx_w;
            slot_m <= nx_m;
            if (bubble) begin
                slot_e   <= '0;
                rs_e     <= '0;
                rt_e     <= '0;
                fwd_rs_e <= FWD_RF;
                fwd_rt_e <= FWD_RF;
            end else begin
                slot_e   <= '{dst: dst_d, tnew: tnew_d};
                rs_e     <= rs_d;
                rt_e     <= rt_d;
                fwd_rs_e <= sel_rs_nx;
                fwd_rt_e <= sel_rt_nx;
            end
        end
    end

    // Tnew of whatever stage each D select points at (0 for the regfile).
    logic [TW-1:0] src_tnew_rs;
    logic [TW-1:0] src_tnew_rt;

    always_comb begin
        src_tnew_rs = '0;
        src_tnew_rt = '0;
        case (sel_rs_d)
            FWD_E:   src_tnew_rs = slot_e.tnew;
            FWD_M:   src_tnew_rs = slot_m.tnew;
            FWD_W:   src_tnew_rs = slot_w.tnew;
            default: src_tnew_rs = '0;
        endcase
        case (sel_rt_d)
            FWD_E:   src_tnew_rt = slot_e.tnew;
            FWD_M:   src_tnew_rt = slot_m.tnew;
            FWD_W:   src_tnew_rt = slot_w.tnew;
            default: src_tnew_rt = '0;
        endcase
    end

    // An unstalled cycle never forwards a value that is not yet produced.
    a_fwd_ready: assert property (@(negedge clk) disable iff (reset)
        !stall |-> ((src_tnew_rs == '0) && (src_tnew_rt == '0)));

    // The precompute runs with Tuse "not read" and so can never stall.
    a_pre_no_stall: assert property (@(negedge clk) disable iff (reset)
        !(pre_stall_rs || pre_stall_rt));

    // A non-zero E select always belongs to a real (non-$0) operand.
    a_e_sel_reg: assert property (@(negedge clk) disable iff (reset)
        ((fwd_rs_e == 2'd0) || (rs_e != '0)) && ((fwd_rt_e == 2'd0) || (rt_e != '0)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model
// that tracks issued instructions by age rather than by slot registers.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs_d;
    logic [AW-1:0] rt_d;
    logic [TW-1:0] tuse_rs_d;
    logic [TW-1:0] tuse_rt_d;
    logic [AW-1:0] dst_d;
    logic [TW-1:0] tnew_d;
    logic          flush;
    logic          stall;
    logic [1:0]    fwd_rs_d;
    logic [1:0]    fwd_rt_d;
    logic [1:0]    fwd_rs_e;
    logic [1:0]    fwd_rt_e;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .tuse_rs_d(tuse_rs_d),
        .tuse_rt_d(tuse_rt_d),
        .dst_d    (dst_d),
        .tnew_d   (tnew_d),
        .flush    (flush),
        .stall    (stall),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist index = cycles since issue (0: in E, 1: in M, 2: in W);
    // m_t holds the Tnew the instruction was issued with.
    int m_dst[3];
    int m_t[3];
    int m_fe_rs;
    int m_fe_rt;

    function automatic int remaining(int k);
        if (k == 2) return 0;
        return (m_t[k] > k) ? m_t[k] - k : 0;
    endfunction

    function automatic void resolve(input int r, input int tuse, input int first,
                                    output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (r == 0) return;
        for (int k = first; k < 3; k++) begin
            if (m_dst[k] == r) begin
                st  = (tuse != 3) && (remaining(k) > tuse);
                sel = (remaining(k) == 0) ? k + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            m_dst[k] = 0;
            m_t[k]   = 0;
        end
        m_fe_rs = 0;
        m_fe_rt = 0;
    endfunction

    task automatic model_compare(input string tag);
        bit s1, s2;
        int f1, f2;
        resolve(int'(rs_d), int'(tuse_rs_d), 0, s1, f1);
        resolve(int'(rt_d), int'(tuse_rt_d), 0, s2, f2);
        check({tag, "_m_stall"},    stall,    32'(s1 | s2));
        check({tag, "_m_fwd_rs_d"}, fwd_rs_d, f1);
        check({tag, "_m_fwd_rt_d"}, fwd_rt_d, f2);
        check({tag, "_m_fwd_rs_e"}, fwd_rs_e, m_fe_rs);
        check({tag, "_m_fwd_rt_e"}, fwd_rt_e, m_fe_rt);
    endtask

    // Drive D inputs just after a posedge, then sample at the negedge.
    task automatic apply(input string tag, input int rs, input int rt, input int tu_rs,
                         input int tu_rt, input int dst, input int tn, input int fl);
        rs_d      = AW'(rs);
        rt_d      = AW'(rt);
        tuse_rs_d = TW'(tu_rs);
        tuse_rt_d = TW'(tu_rt);
        dst_d     = AW'(dst);
        tnew_d    = TW'(tn);
        flush     = fl[0];
        @(negedge clk);
        model_compare(tag);
    endtask

    // Advance one edge and move the model along with it.
    task automatic tick();
        bit s1, s2, bub, sx;
        int f1, f2, e1, e2;
        resolve(int'(rs_d), int'(tuse_rs_d), 0, s1, f1);
        resolve(int'(rt_d), int'(tuse_rt_d), 0, s2, f2);
        bub = s1 | s2 | flush;
        @(posedge clk);
        m_dst[2] = m_dst[1];
        m_t[2]   = m_t[1];
        m_dst[1] = m_dst[0];
        m_t[1]   = m_t[0];
        if (bub) begin
            m_dst[0] = 0;
            m_t[0]   = 0;
            m_fe_rs  = 0;
            m_fe_rt  = 0;
        end else begin
            resolve(int'(rs_d), 3, 1, sx, e1);
            resolve(int'(rt_d), 3, 1, sx, e2);
            m_fe_rs  = e1;
            m_fe_rt  = e2;
            m_dst[0] = int'(dst_d);
            m_t[0]   = int'(tnew_d);
        end
        #1;
    endtask

    // Raise reset between edges, check the cleared outputs, release after a posedge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_clear();
        check({tag, "_stall"},    stall,    0);
        check({tag, "_fwd_rs_d"}, fwd_rs_d, 0);
        check({tag, "_fwd_rt_d"}, fwd_rt_d, 0);
        check({tag, "_fwd_rs_e"}, fwd_rs_e, 0);
        check({tag, "_fwd_rt_e"}, fwd_rt_e, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rs, rt, tu_rs, tu_rt, dst, tn, fl;
        int st, frs, frt, ers, ert;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rs, int rt, int tu_rs, int tu_rt, int dst, int tn, int fl,
                                int st, int frs, int frt, int ers, int ert);
        vec_t v;
        v.rs = rs; v.rt = rt; v.tu_rs = tu_rs; v.tu_rt = tu_rt;
        v.dst = dst; v.tn = tn; v.fl = fl;
        v.st = st; v.frs = frs; v.frt = frt; v.ers = ers; v.ert = ert;
        return v;
    endfunction

    function automatic vec_t nop(int ers, int ert);
        return mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ers, ert);
    endfunction

    initial begin
        reset = 1'b0;
        rs_d = '0; rt_d = '0; tuse_rs_d = TUSE_NONE; tuse_rt_d = TUSE_NONE;
        dst_d = '0; tnew_d = '0; flush = 1'b0;
        model_clear();
        #1;
        do_reset("por");

        // lw $8; addu reads $8 at E: one stall, then the load is in W
        // by the time addu reaches E.
        vecs.push_back(mk(0, 0, 3, 3, 8, 2, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(8, 0, 1, 3, 10, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(8, 0, 1, 3, 10, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(3, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // lw $8; beq reads $8 in D: two stalls, then forward from W.
        vecs.push_back(mk(0, 0, 3, 3, 8, 2, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(8, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(8, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(8, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        // addu $9; addu reads $9 at E: no stall, forward from M in E.
        vecs.push_back(mk(0, 0, 3, 3, 9, 1, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(9, 0, 1, 3, 11, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(2, 0));
        vecs.push_back(nop(0, 0));
        vecs.push_back(nop(0, 0));
        // write to $0 then read $0 in D: never a hazard.
        vecs.push_back(mk(0, 0, 3, 3, 0, 2, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0));
        // rt path: addu $7; reader uses $7 as rt at E.
        vecs.push_back(mk(0, 0, 3, 3, 7, 1, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 7, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply(t, vecs[i].rs, vecs[i].rt, vecs[i].tu_rs, vecs[i].tu_rt,
                  vecs[i].dst, vecs[i].tn, vecs[i].fl);
            check({t, "_stall"},    stall,    vecs[i].st);
            check({t, "_fwd_rs_d"}, fwd_rs_d, vecs[i].frs);
            check({t, "_fwd_rt_d"}, fwd_rt_d, vecs[i].frt);
            check({t, "_fwd_rs_e"}, fwd_rs_e, vecs[i].ers);
            check({t, "_fwd_rt_e"}, fwd_rt_e, vecs[i].ert);
            tick();
        end

        // $5 written by E (tnew 1) and M (tnew 0): the nearer E copy decides.
        do_reset("rst_a");
        apply("same_a", 0, 0, 3, 3, 5, 1, 0); tick();
        apply("same_b", 0, 0, 3, 3, 5, 1, 0); tick();
        apply("same_c", 5, 5, 0, 3, 12, 0, 0);
        check("same_stall",    stall,    1);
        check("same_fwd_rs_d", fwd_rs_d, 0);
        check("same_fwd_rt_d", fwd_rt_d, 0);
        tick();
        apply("same_d", 5, 5, 0, 3, 12, 0, 0);
        check("same_release",  stall,    0);
        check("same_fwd_m",    fwd_rs_d, 2);
        tick();

        // Reset while stalled with a live E select: all drops immediately.
        do_reset("rst_b");
        apply("mid_a", 0, 0, 3, 3, 9, 1, 0); tick();
        apply("mid_b", 9, 0, 1, 3, 10, 1, 0); tick();
        apply("mid_c", 9, 0, 1, 3, 8, 2, 0);
        check("mid_c_stall", stall,    0);
        check("mid_c_fwd",   fwd_rs_d, 2);
        tick();
        apply("mid_d", 8, 0, 0, 3, 0, 0, 0);
        check("mid_d_stall",  stall,    1);
        check("mid_d_fwd_e",  fwd_rs_e, 3);
        do_reset("mid_reset");

        // Flush alone empties E; flush with stall is still one bubble.
        apply("fl_a", 0, 0, 3, 3, 12, 1, 1); tick();
        apply("fl_b", 12, 0, 0, 3, 0, 0, 0);
        check("flush_no_stall", stall,    0);
        check("flush_no_fwd",   fwd_rs_d, 0);
        tick();
        apply("fs_a", 0, 0, 3, 3, 8, 2, 0); tick();
        apply("fs_b", 8, 0, 1, 3, 10, 1, 1);
        check("fs_stall", stall, 1);
        tick();
        apply("fs_c", 8, 0, 1, 3, 10, 1, 0);
        check("fs_one_bubble", stall, 0);
        tick();
        apply("fs_d", 0, 0, 3, 3, 0, 0, 0);
        check("fs_fwd_e", fwd_rs_e, 3);
        tick();

        // Randomized traffic on a small register set to force collisions.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd_reset");
            apply("rnd",
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 1 : 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
